vl_element_sequencer: RTL and testbench
=======================================

// Module: vl_element_sequencer
// PURPOSE
//  Consumer of the committed vl/vtype pair produced by vsetvl processing.
//  Takes one vector op (vl, vtype, base register vd) per handshake and walks it
//  element by element: emits element index, physical register in the LMUL group,
//  and byte offset within the VLEN register, with a valid/ready handshake
//  toward the vector lanes. Sits between vector decode and the vector datapath.
// PARAMETERS
//  VLEN       64  vector register width in bits (only 64 is supported)
//  VREG_W     5   width of vector register specifier (32 registers)
// PORTS
//  clk           in   1  clock, rising edge
//  rst           in   1  asynchronous, active-high reset
//  in_valid      in   1  op request valid
//  in_ready      out  1  sequencer can accept an op (high only in IDLE)
//  in_vl         in   7  element count, 0..64
//  in_vtype      in   7  [6]=vtype valid, [5:3]=SEW enc, [2:0]=LMUL enc
//  in_vd         in   5  base register of the group
//  out_valid     out  1  element micro-op valid
//  out_ready     in   1  lanes accept the micro-op
//  out_elem_idx  out  7  element index, 0..vl-1
//  out_vreg      out  5  physical register = vd + (idx >> (3-SEW))
//  out_byte_off  out  3  byte offset in register = (idx << SEW) mod 8
//  out_sew       out  2  SEW enc of the op: 0=8b, 1=16b, 2=32b, 3=64b
//  out_last      out  1  high on element vl-1
//  done          out  1  one-cycle pulse: op finished (incl. vl==0)
//  err           out  1  one-cycle pulse: op rejected
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid, out_last, done, err = 0; out_elem_idx,
//    out_vreg, out_byte_off, out_sew = 0. in_ready = 1 once reset deasserts.
//  - Encodings: SEW enc 0..3 -> 8/16/32/64 bits; LMUL enc 0..3 -> 1/2/4/8 regs.
//    elems/reg = 8 >> SEW; vlmax = (8 >> SEW) << LMUL (1..64, 7 bits, no overflow).
//  - FSM states: IDLE and ISSUE. in_ready = (state==IDLE).
//  - IDLE, in_valid high (accept cycle), checks in priority order:
//    1) in_vtype[6]==0 or SEW[2] or LMUL[2] -> err pulse next cycle, stay IDLE
//    2) in_vl > vlmax -> err pulse, stay IDLE
//    3) in_vd not a multiple of (1<<LMUL) -> err pulse, stay IDLE
//    4) in_vl == 0 -> done pulse next cycle, stay IDLE, no micro-ops
//    5) else latch vl/SEW/LMUL/vd, idx=0, go ISSUE; out_valid high next cycle
//  - ISSUE: out_valid=1; all out_* are registered and stable while
//    out_valid && !out_ready (no change, no drop). On out_valid && out_ready:
//    idx+1 and new fields next cycle. When the element with out_last is taken:
//    out_valid=0, done pulses one cycle, go IDLE. Back-to-back ops: a new op can be
//    accepted the cycle after done, so there is a 1-cycle bubble minimum.
//  - Throughput: 1 element/cycle while out_ready held high. First micro-op 1 cycle
//    after accept.
//  - out_vreg never exceeds vd + (1<<LMUL) - 1 and never wraps past 31. The
//    alignment check plus vl<=vlmax guarantees this.
//  - err and done never pulse in the same cycle. Inputs are ignored outside IDLE.
//  - Reset mid-ISSUE: op aborted immediately (async), no done/err, all outputs
//    take their reset values.
// TESTING
//  - SEW=0,LMUL=0,vl=8,vd=4, out_ready=1 -> idx 0..7, vreg=4, byte_off 0..7,
//    last on idx 7, done 1 cycle after it
//  - SEW=2,LMUL=1,vl=3,vd=6 -> (idx,vreg,off)=(0,6,0),(1,6,4),(2,7,0); last on idx 2
//  - SEW=0,LMUL=3,vl=64,vd=8 -> 64 micro-ops, vreg 8..15, idx 63 last; out_ready
//    toggled 1/0 each cycle -> fields held while stalled, no loss, no duplicate
//  - vtype[6]=0 or vl=9 with SEW=0,LMUL=0 or vd=3 with LMUL=1 -> err pulse,
//    no out_valid, in_ready stays 1
//  - vl=0 valid vtype -> done pulse only; then a new op is accepted next cycle
//  - rst asserted at idx 5 of a 16-element op -> out_valid=0 at once, no done;
//    next op after reset starts at idx 0

Source files
------------

// File: rtl/vl_element_sequencer.sv
// vl_element_sequencer
// Takes one committed vector op (vl, vtype, base register vd) per handshake
// and walks it one element at a time. Each micro-op carries the element
// index, the physical register inside the LMUL group and the byte offset
// inside that register. Malformed ops are rejected with an err pulse, and
// vl==0 ops finish immediately with a done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for an op; in_ready high; checks and latches op
// S_ISSUE | presenting micro-ops; fields held while the lanes stall
module vl_element_sequencer #(
  parameter int VLEN   = 64,
  parameter int VREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_vl,
  input  logic [6:0]        in_vtype,
  input  logic [VREG_W-1:0] in_vd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_elem_idx,
  output logic [VREG_W-1:0] out_vreg,
  output logic [2:0]        out_byte_off,
  output logic [1:0]        out_sew,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // Elements per register at SEW=8; only VLEN=64 is supported, giving 8.
  localparam logic [7:0] ELEMS_E8 = 8'(VLEN / 8);

  logic [0:0]        r_state;
  logic [6:0]        r_vl;
  logic [1:0]        r_sew;
  logic [VREG_W-1:0] r_vd;
  logic [6:0]        r_idx;
  logic [VREG_W-1:0] r_vreg;
  logic [2:0]        r_byte_off;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic              r_err;

  logic [1:0]        w_sew;
  logic [1:0]        w_lmul;
  logic              w_bad_vtype;
  logic [7:0]        w_vlmax;
  logic              w_vl_too_big;
  logic [VREG_W-1:0] w_align_mask;
  logic              w_misaligned;
  logic [6:0]        w_idx_nxt;
  logic [6:0]        w_grp_off;
  logic [2:0]        w_off_nxt;
  logic              w_last_nxt;

  assign w_sew        = in_vtype[4:3];
  assign w_lmul       = in_vtype[1:0];
  // Reserved SEW/LMUL encodings (bit 2 set) are treated like an invalid vtype.
  assign w_bad_vtype  = !in_vtype[6] || in_vtype[5] || in_vtype[2];
  assign w_vlmax      = (ELEMS_E8 >> w_sew) << w_lmul;
  assign w_vl_too_big = {1'b0, in_vl} > w_vlmax;
  assign w_align_mask = VREG_W'((1 << w_lmul) - 1);
  assign w_misaligned = |(in_vd & w_align_mask);

  assign w_idx_nxt  = r_idx + 7'd1;
  assign w_last_nxt = (w_idx_nxt == (r_vl - 7'd1));

  // Register within the group and byte offset of the following element.
  always_comb begin
    w_grp_off = 7'd0;
    w_off_nxt = 3'd0;
    case (r_sew)
      2'd0: begin
        w_grp_off = w_idx_nxt >> 3;
        w_off_nxt = w_idx_nxt[2:0];
      end
      2'd1: begin
        w_grp_off = w_idx_nxt >> 2;
        w_off_nxt = {w_idx_nxt[1:0], 1'b0};
      end
      2'd2: begin
        w_grp_off = w_idx_nxt >> 1;
        w_off_nxt = {w_idx_nxt[0], 2'b00};
      end
      default: begin
        w_grp_off = w_idx_nxt;
        w_off_nxt = 3'd0;
      end
    endcase
  end

  // Op acceptance, rejection and per-element issue with stall hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_vl       <= 7'd0;
      r_sew      <= 2'd0;
      r_vd       <= '0;
      r_idx      <= 7'd0;
      r_vreg     <= '0;
      r_byte_off <= 3'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_bad_vtype || w_vl_too_big || w_misaligned) begin
              r_err <= 1'b1;
            end else if (in_vl == 7'd0) begin
              r_done <= 1'b1;
            end else begin
              r_vl       <= in_vl;
              r_sew      <= w_sew;
              r_vd       <= in_vd;
              r_idx      <= 7'd0;
              r_vreg     <= in_vd;
              r_byte_off <= 3'd0;
              r_valid    <= 1'b1;
              r_last     <= (in_vl == 7'd1);
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_vreg     <= r_vd + w_grp_off[VREG_W-1:0];
              r_byte_off <= w_off_nxt;
              r_last     <= w_last_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = r_valid;
  assign out_elem_idx = r_idx;
  assign out_vreg     = r_vreg;
  assign out_byte_off = r_byte_off;
  assign out_sew      = r_sew;
  assign out_last     = r_last;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_vl_element_sequencer.sv
// Directed bench for vl_element_sequencer: element walks at several SEW/LMUL
// settings, stall hold, rejects, vl==0, back-to-back ops and mid-op reset.
module tb_vl_element_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_vl = 7'd0;
  logic [6:0] in_vtype = 7'd0;
  logic [4:0] in_vd = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] out_elem_idx;
  logic [4:0] out_vreg;
  logic [2:0] out_byte_off;
  logic [1:0] out_sew;
  logic       out_last;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  vl_element_sequencer #(.VLEN(64), .VREG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vl(in_vl), .in_vtype(in_vtype), .in_vd(in_vd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_elem_idx(out_elem_idx), .out_vreg(out_vreg),
    .out_byte_off(out_byte_off), .out_sew(out_sew), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] vt(input int sew, input int lmul);
    return {1'b1, 3'(sew), 3'(lmul)};
  endfunction

  // Present one op for a single accept cycle; call at a negedge while idle.
  task automatic issue(input int vl, input logic [6:0] vtype, input int vd);
    in_valid = 1'b1;
    in_vl    = 7'(vl);
    in_vtype = vtype;
    in_vd    = 5'(vd);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Follow the micro-op stream of an accepted op and compare every cycle.
  // stop_at >= 0 returns while element stop_at is presented, untaken.
  task automatic walk(input int vl, input int sew, input int vd,
                      input bit toggle, input int stop_at);
    int idx = 0;
    int cyc = 0;
    logic [18:0] exp_uop;
    while (idx < vl && cyc < 400) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      exp_uop = {1'b1, 7'(idx), 5'(vd + (idx >> (3 - sew))),
                 3'((idx << sew) % 8), 2'(sew), (idx == vl - 1)};
      checks++;
      if ({out_valid, out_elem_idx, out_vreg, out_byte_off, out_sew, out_last} !== exp_uop) begin
        errors++;
        $display("FAIL uop idx=%0d: got v=%0b idx=%0d vreg=%0d off=%0d sew=%0d last=%0b, exp vreg=%0d off=%0d last=%0b",
                 idx, out_valid, out_elem_idx, out_vreg, out_byte_off, out_sew, out_last,
                 exp_uop[10:6], exp_uop[5:3], exp_uop[0]);
      end
      checks++;
      if ({in_ready, done, err} !== 3'b000) begin
        errors++;
        $display("FAIL issue_flags idx=%0d: got ready/done/err=%b exp 000", idx, {in_ready, done, err});
      end
      if (idx == stop_at) return;
      if (out_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (idx < vl) begin
      errors++;
      $display("FAIL walk_timeout: got %0d elements exp %0d", idx, vl);
    end
    checks++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL done_pulse: got done/valid/ready=%b exp 101", {done, out_valid, in_ready});
    end
    @(negedge clk);
    checks++;
    if ({done, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL done_width: got done/valid=%b exp 00", {done, out_valid});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_elem_idx, out_vreg, out_byte_off, out_sew, out_last, done, err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b idx=%0d vreg=%0d off=%0d sew=%0d last=%0b done=%0b err=%0b exp all 0",
               out_valid, out_elem_idx, out_vreg, out_byte_off, out_sew, out_last, done, err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_sew8_single();
    issue(8, vt(0, 0), 4);
    walk(8, 0, 4, 1'b0, -1);
  endtask

  task automatic test_sew32_lmul2();
    issue(3, vt(2, 1), 6);
    walk(3, 2, 6, 1'b0, -1);
  endtask

  task automatic test_sew64_lmul4();
    issue(4, vt(3, 2), 12);
    walk(4, 3, 12, 1'b0, -1);
  endtask

  task automatic test_stall_lmul8();
    issue(64, vt(0, 3), 8);
    walk(64, 0, 8, 1'b1, -1);
  endtask

  task automatic test_reject();
    logic [6:0] vts [4] = '{7'b0000000, vt(0, 0), vt(0, 1), 7'b1100000};
    int         vls [4] = '{4, 9, 2, 1};
    int         vds [4] = '{0, 0, 3, 0};
    for (int i = 0; i < 4; i++) begin
      issue(vls[i], vts[i], vds[i]);
      checks++;
      if ({err, done, out_valid, in_ready} !== 4'b1001) begin
        errors++;
        $display("FAIL reject_%0d: got err/done/valid/ready=%b exp 1001", i, {err, done, out_valid, in_ready});
      end
      @(negedge clk);
      checks++;
      if ({err, done, out_valid, in_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reject_after_%0d: got err/done/valid/ready=%b exp 0001", i, {err, done, out_valid, in_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(0, vt(1, 0), 2);
    checks++;
    if ({done, err, out_valid, in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL vl0_done: got done/err/valid/ready=%b exp 1001", {done, err, out_valid, in_ready});
    end
    issue(4, vt(1, 0), 1);
    walk(4, 1, 1, 1'b0, -1);
    issue(2, vt(0, 0), 0);
    walk(2, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_op();
    issue(16, vt(0, 1), 2);
    walk(16, 0, 2, 1'b0, 5);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_elem_idx, out_vreg, out_byte_off, out_sew, out_last, done, err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_abort: got v=%0b idx=%0d vreg=%0d off=%0d done=%0b exp all 0",
               out_valid, out_elem_idx, out_vreg, out_byte_off, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, err, out_valid, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_after: got done/err/valid/ready=%b exp 0001", {done, err, out_valid, in_ready});
    end
    issue(3, vt(0, 0), 0);
    walk(3, 0, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_sew8_single();
    test_sew32_lmul2();
    test_sew64_lmul4();
    test_stall_lmul8();
    test_reject();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
